sprite_pattern_shifter: RTL

Sprite bit-plane shift stage of the DMG pixel pipeline. It sits directly upstream of the sprite palette shifter. It takes the two tile bytes delivered by the sprite fetcher, applies X-flip, and merges them only into transparent slots, so the earlier-loaded sprite keeps priority. It then shifts the planes out one pixel per pixel-clock enable. Its 8-bit plane vectors feed the palette shifter's transparency and load logic, and its bit-7 outputs feed the final pixel mux.

---
 rtl/ppu_pkg.sv | 19 +
 rtl/spr_plane_reg.sv | 35 +++
 rtl/sprite_pattern_shifter.sv | 89 ++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared DMG pixel-pipeline definitions: sprite row width, per-line sprite
// limit, the row type and the X-flip helper used by both sprite shifters.
package ppu_pkg;

    localparam int unsigned SPR_ROW_W        = 8;
    localparam int unsigned SPR_MAX_PER_LINE = 10;

    typedef logic [SPR_ROW_W-1:0] spr_row_t;

    // Mirror a tile row when flip is set (bit i takes bit 7-i).
    function automatic spr_row_t spr_row_flip(spr_row_t row, logic flip);
        spr_row_t res;
        for (int i = 0; i < SPR_ROW_W; i++) begin
            res[i] = flip ? row[SPR_ROW_W-1-i] : row[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/spr_plane_reg.sv
// One sprite bit-plane: shift toward slot 7, masked merge, synchronous clear.
module spr_plane_reg
    import ppu_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     clear,
    input  logic     shift,
    input  spr_row_t mask,
    input  spr_row_t row,
    output spr_row_t q
);

    spr_row_t shifted;
    spr_row_t q_d;

    // Shift first, then merge the row only into masked slots; clear wins.
    always_comb begin
        shifted = shift ? {q[SPR_ROW_W-2:0], 1'b0} : q;
        q_d     = (shifted & ~mask) | (row & mask);
        if (clear) begin
            q_d = '0;
        end
    end

    // Plane state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/sprite_pattern_shifter.sv
// Sprite bit-plane shift stage. Merges fetched sprite rows into transparent
// slots only, so earlier sprites keep priority, and shifts one pixel per
// pix_en. Optional load counter / overflow flag: define SPR_LOAD_COUNT_EN.
module sprite_pattern_shifter
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       line_start,
    input  logic       pix_en,
    input  logic       load,
    input  logic [7:0] tile_lo,
    input  logic [7:0] tile_hi,
    input  logic       xflip,
    output logic [7:0] spr_pix_a,
    output logic [7:0] spr_pix_b,
    output logic [7:0] load_mask,
    output logic [1:0] spr_pix
`ifdef SPR_LOAD_COUNT_EN
    ,
    output logic [3:0] spr_count,
    output logic       spr_overflow
`endif
);

    spr_row_t row_lo;
    spr_row_t row_hi;
    spr_row_t post_a;
    spr_row_t post_b;

    // Align the row and mask against post-shift slot occupancy.
    always_comb begin
        row_lo    = spr_row_flip(tile_lo, xflip);
        row_hi    = spr_row_flip(tile_hi, xflip);
        post_a    = pix_en ? {spr_pix_a[SPR_ROW_W-2:0], 1'b0} : spr_pix_a;
        post_b    = pix_en ? {spr_pix_b[SPR_ROW_W-2:0], 1'b0} : spr_pix_b;
        load_mask = {SPR_ROW_W{load}} & ~(post_a | post_b);
    end

    spr_plane_reg u_plane_a (
        .clk   (clk),
        .reset (reset),
        .clear (line_start),
        .shift (pix_en),
        .mask  (load_mask),
        .row   (row_lo),
        .q     (spr_pix_a)
    );

    spr_plane_reg u_plane_b (
        .clk   (clk),
        .reset (reset),
        .clear (line_start),
        .shift (pix_en),
        .mask  (load_mask),
        .row   (row_hi),
        .q     (spr_pix_b)
    );

    assign spr_pix = {spr_pix_b[SPR_ROW_W-1], spr_pix_a[SPR_ROW_W-1]};

`ifdef SPR_LOAD_COUNT_EN
    localparam logic [3:0] CountMax = 4'(SPR_MAX_PER_LINE);

    logic [3:0] count_q;
    logic       overflow_q;

    // Per-line load counter, saturating; overflow is sticky until line_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (line_start) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (load) begin
            if (count_q == CountMax) begin
                overflow_q <= 1'b1;
            end else begin
                count_q <= count_q + 4'd1;
            end
        end
    end

    assign spr_count    = count_q;
    assign spr_overflow = overflow_q;
`endif

endmodule
